// File: rtl/robot_ctrl.sv
// Left-hand wall-following decision core for the pipe-cleaning robot, with trash removal.
// Define ROBOT_BLACK_HALT_EN to let the under sensor stop the robot on a black block.
module robot_ctrl #(
  parameter int unsigned REMOVE_CYCLES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic head,
  input  logic left,
  input  logic under,
  input  logic barrier,
  output logic front,
  output logic turn,
  output logic remove
);

  typedef enum logic [2:0] {
    SEARCH = 3'd0,
    FOLLOW = 3'd1,
    STEP   = 3'd2,
    ROT2   = 3'd3,
    ROT3   = 3'd4,
    REMOVE = 3'd5,
    HALT   = 3'd6
  } state_e;

  localparam logic [2:0] RemoveCycles = 3'(REMOVE_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wall_q, wall_d;
  logic       underHit;
  state_e     returnState;

`ifdef ROBOT_BLACK_HALT_EN
  assign underHit = under;
`else
  logic unusedUnder;
  assign unusedUnder = under;
  assign underHit    = 1'b0;
`endif

  assign returnState = wall_q ? FOLLOW : SEARCH;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
      cnt_q   <= 3'd0;
      wall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wall_q  <= wall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wall_d  = wall_q;
    unique case (state_q)
      SEARCH, FOLLOW, STEP: begin
        if (underHit) begin
          state_d = HALT;
        end else if (barrier) begin
          // A single-cycle removal finishes on the entry edge itself.
          if (RemoveCycles == 3'd1) begin
            cnt_d   = 3'd0;
            state_d = returnState;
          end else begin
            cnt_d   = 3'd1;
            state_d = REMOVE;
          end
        end else if (state_q == STEP) begin
          state_d = head ? ROT2 : FOLLOW;
        end else if (state_q == SEARCH && !left) begin
          if (head) begin
            state_d = ROT2;
            wall_d  = 1'b1;
          end
        end else begin
          wall_d = 1'b1;
          if (!left)      state_d = STEP;
          else if (!head) state_d = FOLLOW;
          else            state_d = ROT2;
        end
      end
      ROT2: state_d = ROT3;
      ROT3: state_d = FOLLOW;
      REMOVE: begin
        if (barrier && cnt_q < RemoveCycles) begin
          if (cnt_q + 3'd1 == RemoveCycles) begin
            cnt_d   = 3'd0;
            state_d = returnState;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          cnt_d   = 3'd0;
          state_d = returnState;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    front  = 1'b0;
    turn   = 1'b0;
    remove = 1'b0;
    unique case (state_q)
      SEARCH, FOLLOW, STEP: begin
        if (underHit) begin
          front = 1'b0;
        end else if (barrier) begin
          remove = 1'b1;
        end else if (state_q == STEP || (state_q == SEARCH && !left)) begin
          front = !head;
          turn  = head;
        end else if (!left) begin
          turn = 1'b1;
        end else begin
          front = !head;
          turn  = head;
        end
      end
      ROT2, ROT3: turn = 1'b1;
      REMOVE:     remove = barrier && (cnt_q < RemoveCycles);
      default:    front = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_robot_ctrl.sv
// Scoreboard bench for robot_ctrl: a behavioural model predicts {front,turn,remove} each cycle.
// Compile with ROBOT_BLACK_HALT_EN defined to exercise the black-block halt.
module tb_robot_ctrl;

  localparam int RC = 3;
`ifdef ROBOT_BLACK_HALT_EN
  localparam bit HaltEnabled = 1'b1;
`else
  localparam bit HaltEnabled = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic head    = 1'b0;
  logic left    = 1'b0;
  logic under   = 1'b0;
  logic barrier = 1'b0;
  logic front, turn, remove;

  int checks = 0;
  int errors = 0;
  logic [2:0] expQ[$];
  string      nameQ[$];

  // Model: pending forced turns, removal progress, and whether the last move was a left toward an opening.
  bit mHalted, mWall, mAfterLeft;
  int mForced, mRemoving;
  bit nHalted, nWall, nAfterLeft;
  int nForced, nRemoving;

  robot_ctrl #(.REMOVE_CYCLES(RC)) dut (
    .clock  (clock),
    .reset  (reset),
    .head   (head),
    .left   (left),
    .under  (under),
    .barrier(barrier),
    .front  (front),
    .turn   (turn),
    .remove (remove)
  );

  always #5 clock = ~clock;

  task automatic modelReset();
    mHalted    = 1'b0;
    mWall      = 1'b0;
    mAfterLeft = 1'b0;
    mForced    = 0;
    mRemoving  = 0;
  endtask

  task automatic modelStep(output logic [2:0] e);
    e          = 3'b000;
    nHalted    = mHalted;
    nWall      = mWall;
    nAfterLeft = mAfterLeft;
    nForced    = mForced;
    nRemoving  = mRemoving;
    if (mHalted) begin
      e = 3'b000;
    end else if (mForced > 0) begin
      e       = 3'b010;
      nForced = mForced - 1;
    end else if (mRemoving > 0) begin
      if (barrier && mRemoving < RC) begin
        e         = 3'b001;
        nRemoving = (mRemoving + 1 == RC) ? 0 : mRemoving + 1;
      end else begin
        nRemoving = 0;
      end
    end else if (HaltEnabled && under) begin
      nHalted = 1'b1;
    end else if (barrier) begin
      e          = 3'b001;
      nRemoving  = (RC == 1) ? 0 : 1;
      nAfterLeft = 1'b0;
    end else if (mAfterLeft) begin
      nAfterLeft = 1'b0;
      if (!head) e = 3'b100;
      else begin e = 3'b010; nForced = 2; end
    end else begin
      if (left) nWall = 1'b1;
      if (!nWall) begin
        if (!head) e = 3'b100;
        else begin e = 3'b010; nForced = 2; nWall = 1'b1; end
      end else if (!left) begin
        e          = 3'b010;
        nAfterLeft = 1'b1;
      end else if (!head) begin
        e = 3'b100;
      end else begin
        e       = 3'b010;
        nForced = 2;
      end
    end
  endtask

  task automatic applyStimulus(input string name, input bit rst, input bit h, input bit l,
                               input bit u, input bit b);
    logic [2:0] e;
    @(negedge clock);
    reset   = rst;
    head    = h;
    left    = l;
    under   = u;
    barrier = b;
    #1;
    if (!rst) modelReset();
    modelStep(e);
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge clock);
    if (rst) begin
      mHalted    = nHalted;
      mWall      = nWall;
      mAfterLeft = nAfterLeft;
      mForced    = nForced;
      mRemoving  = nRemoving;
    end
  endtask

  task automatic checkOutput(input string name, input logic [2:0] e);
    logic [2:0] act;
    act = {front, turn, remove};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s: got front/turn/remove=%b, expected %b at %0t", name, act, e, $time);
    end
    checks++;
    if ($countones(act) > 1) begin
      errors++;
      $display("[TB] FAIL %s-onehot: got %b, expected at most one active", name, act);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (expQ.size() > 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
    end
  end

  initial begin
    modelReset();
    applyStimulus("reset", 0, 0, 0, 0, 0);
    applyStimulus("reset", 0, 1, 0, 0, 0);
    repeat (4) applyStimulus("searchFront", 1, 0, 0, 0, 0);
    repeat (3) applyStimulus("rightTurn", 1, 1, 0, 0, 0);
    repeat (2) applyStimulus("followFront", 1, 0, 1, 0, 0);
    applyStimulus("openingTurn", 1, 1, 0, 0, 0);
    applyStimulus("stepFront", 1, 0, 0, 0, 0);
    applyStimulus("followFront", 1, 0, 1, 0, 0);
    repeat (3) applyStimulus("removeHeld", 1, 0, 1, 0, 1);
    applyStimulus("afterRemove", 1, 0, 1, 0, 0);
    applyStimulus("removeShort", 1, 0, 1, 0, 1);
    applyStimulus("trashGone", 1, 0, 1, 0, 0);
    applyStimulus("followFront", 1, 0, 1, 0, 0);
    applyStimulus("rot2Entry", 1, 1, 1, 0, 0);
    applyStimulus("resetInRot", 0, 0, 0, 0, 0);
    applyStimulus("postReset", 1, 0, 0, 0, 0);
    applyStimulus("searchBarrier", 1, 0, 0, 0, 1);
    repeat (3) applyStimulus("searchRemove", 1, 0, 0, 0, 1);
    applyStimulus("searchAgain", 1, 0, 0, 0, 0);

    for (int i = 0; i < 500; i++) begin
      applyStimulus("random", ($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 5) == 0));
    end

    applyStimulus("underFollow", 1, 0, 1, 0, 0);
    applyStimulus("underHit", 1, 0, 1, 1, 0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus("underRandom", 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    applyStimulus("haltReset", 0, 0, 0, 0, 0);
    applyStimulus("haltRelease", 1, 0, 0, 0, 0);

    @(negedge clock);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
